// File: rtl/lcd_refresh_sched_if.sv
// Write handshake between the refresh scheduler and the character LCD driver.
// The master strobes lcd_wr with a held address/word and waits for lcd_done.
interface lcd_refresh_sched_if;
    logic        lcd_wr;
    logic [9:0]  lcd_addr;
    logic [15:0] lcd_data;
    logic        lcd_done;

    modport master (
        output lcd_wr,
        output lcd_addr,
        output lcd_data,
        input  lcd_done
    );

    modport slave (
        input  lcd_wr,
        input  lcd_addr,
        input  lcd_data,
        output lcd_done
    );
endinterface

// File: rtl/lcd_refresh_sched.sv
// Full-screen refresh sequencer for the character LCD: sweeps cells, hands enabled ones to the driver.
// Define AUTO_REFRESH_EN to add a periodic internal refresh request every REFRESH_DIV cycles.
module lcd_refresh_sched #(
    parameter int ROWS        = 4,
    parameter int COLS        = 16,
    parameter int CHAR_LAT    = 2,
    parameter int DONE_TMO    = 1023,
    parameter int REFRESH_DIV = 2500000
) (
    input  logic                       clk_50m,
    input  logic                       rst,
    input  logic [7:0]                 state,
    input  logic                       refresh_req,
    output logic [9:0]                 addr_db,
    input  logic [15:0]                display_reg,
    input  logic                       en_w,
    lcd_refresh_sched_if.master        drv,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       tmo_err
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        WRITE,
        WAIT,
        NEXT
    } fsm_t;

    localparam int CMAX = (DONE_TMO > CHAR_LAT) ? DONE_TMO : CHAR_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    fsm_t        st, st_n;
    logic [5:0]  row, row_n;
    logic [3:0]  col, col_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]  copy, copy_n;
    logic        pending, pend_n;
    logic        restart, rs_n;
    logic        busy_n, done_n, tmo_n;
    logic [9:0]  addr_q, addr_n;
    logic [15:0] data_q, data_n;
    logic        req, chg, redo, last, rewind;

`ifdef AUTO_REFRESH_EN
    localparam int AW = $clog2(REFRESH_DIV);
    logic [AW-1:0] ar_cnt;
    logic          ar_tick;

    assign ar_tick = (ar_cnt == AW'(REFRESH_DIV - 1));

    always_ff @(posedge clk_50m) begin
        if (rst)
            ar_cnt <= '0;
        else if (ar_tick)
            ar_cnt <= '0;
        else
            ar_cnt <= ar_cnt + AW'(1);
    end

    assign req = refresh_req | ar_tick;
`else
    logic unused_div;
    assign unused_div = (REFRESH_DIV == 0);
    assign req = refresh_req;
`endif

    assign chg  = (state != copy);
    assign redo = chg | restart;
    assign last = (row == 6'(ROWS - 1)) && (col == 4'(COLS - 1));

    assign addr_db      = {row, col};
    assign drv.lcd_wr   = (st == WRITE);
    assign drv.lcd_addr = addr_q;
    assign drv.lcd_data = data_q;

    always_comb begin
        st_n   = st;
        row_n  = row;
        col_n  = col;
        cnt_n  = cnt;
        copy_n = copy;
        pend_n = pending;
        rs_n   = restart;
        busy_n = busy;
        done_n = 1'b0;
        tmo_n  = tmo_err;
        addr_n = addr_q;
        data_n = data_q;
        rewind = 1'b0;

        // A state change mid-frame is remembered until the current handshake ends.
        if (st != IDLE) begin
            if (chg) begin
                copy_n = state;
                rs_n   = 1'b1;
            end
            if (req && !redo)
                pend_n = 1'b1;
        end

        unique case (st)
            IDLE: begin
                if (req || pending || chg) begin
                    st_n   = SETTLE;
                    row_n  = '0;
                    col_n  = '0;
                    cnt_n  = '0;
                    busy_n = 1'b1;
                    pend_n = 1'b0;
                    copy_n = state;
                end
            end
            SETTLE: begin
                if (redo)
                    rewind = 1'b1;
                else if (cnt == CW'(CHAR_LAT - 1))
                    st_n = SAMPLE;
                else
                    cnt_n = cnt + CW'(1);
            end
            SAMPLE: begin
                if (redo) begin
                    rewind = 1'b1;
                end else if (en_w) begin
                    addr_n = {row, col};
                    data_n = display_reg;
                    st_n   = WRITE;
                end else begin
                    st_n = NEXT;
                end
            end
            WRITE: begin
                st_n  = WAIT;
                cnt_n = '0;
            end
            WAIT: begin
                if (drv.lcd_done) begin
                    if (redo) rewind = 1'b1;
                    else      st_n = NEXT;
                end else if (cnt == CW'(DONE_TMO - 1)) begin
                    tmo_n = 1'b1;
                    if (redo) rewind = 1'b1;
                    else      st_n = NEXT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            NEXT: begin
                if (redo) begin
                    rewind = 1'b1;
                end else if (last) begin
                    row_n  = '0;
                    col_n  = '0;
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    st_n   = IDLE;
                end else begin
                    if (col == 4'(COLS - 1)) begin
                        col_n = '0;
                        row_n = row + 6'd1;
                    end else begin
                        col_n = col + 4'd1;
                    end
                    cnt_n = '0;
                    st_n  = SETTLE;
                end
            end
            default: st_n = IDLE;
        endcase

        // Restart sweeps from cell 0 and absorbs any queued refresh.
        if (rewind) begin
            st_n   = SETTLE;
            row_n  = '0;
            col_n  = '0;
            cnt_n  = '0;
            rs_n   = 1'b0;
            pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            st         <= IDLE;
            row        <= '0;
            col        <= '0;
            cnt        <= '0;
            copy       <= state;
            pending    <= 1'b0;
            restart    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tmo_err    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            st         <= st_n;
            row        <= row_n;
            col        <= col_n;
            cnt        <= cnt_n;
            copy       <= copy_n;
            pending    <= pend_n;
            restart    <= rs_n;
            busy       <= busy_n;
            frame_done <= done_n;
            tmo_err    <= tmo_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
        end
    end

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Randomized bench for lcd_refresh_sched: generator, driver and expected cell order modelled here.
// Covers full frames, skipped cells, restart on state change, queued refresh, timeout and reset.
module tb_lcd_refresh_sched;

    localparam int ROWS     = 4;
    localparam int COLS     = 16;
    localparam int CHAR_LAT = 2;
    localparam int DONE_TMO = 15;
    localparam int NCELL    = ROWS * COLS;

    logic        clk_50m = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  state = 8'h01;
    logic        refresh_req = 1'b0;
    logic [9:0]  addr_db;
    logic [15:0] display_reg;
    logic        en_w;
    logic        busy;
    logic        frame_done;
    logic        tmo_err;

    lcd_refresh_sched_if bus();

    lcd_refresh_sched #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CHAR_LAT    (CHAR_LAT),
        .DONE_TMO    (DONE_TMO),
        .REFRESH_DIV (2000)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .state       (state),
        .refresh_req (refresh_req),
        .addr_db     (addr_db),
        .display_reg (display_reg),
        .en_w        (en_w),
        .drv         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .tmo_err     (tmo_err)
    );

    always #10 clk_50m = ~clk_50m;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mask = '1;
    bit          done_on = 1'b1;
    int          fix_lat = 3;
    int          cyc = 0;
    logic [9:0]  obs[$];
    int          wr_cyc[$];
    int          fd_cyc[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  d1 = '0;
    logic [9:0]  d2 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gen(input logic [9:0] a);
        return {a[7:0] ^ 8'h5A, a[7:0] + 8'h21};
    endfunction

    function automatic int cell_of(input logic [9:0] a);
        return int'(a[9:4]) * COLS + int'(a[3:0]);
    endfunction

    function automatic logic [9:0] addr_of(input int i);
        return {6'(i / COLS), 4'(i % COLS)};
    endfunction

    function automatic void add_cells(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (mask[i]) exp_q.push_back(addr_of(i));
    endfunction

    // Content generator: word and enable follow addr_db after CHAR_LAT cycles.
    always @(posedge clk_50m) begin
        d1 <= addr_db;
        d2 <= d1;
    end
    assign display_reg = gen(d2);
    assign en_w        = mask[cell_of(d2)];

    initial begin
        forever begin
            @(negedge clk_50m);
            cyc++;
            if (bus.lcd_wr) begin
                obs.push_back(bus.lcd_addr);
                wr_cyc.push_back(cyc);
                chk("data", bus.lcd_data, gen(bus.lcd_addr));
            end
            if (frame_done)
                fd_cyc.push_back(cyc);
        end
    end

    initial begin
        logic [9:0]  ha;
        logic [15:0] hd;
        int          n;
        bus.lcd_done = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (bus.lcd_wr && done_on) begin
                n  = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
                ha = bus.lcd_addr;
                hd = bus.lcd_data;
                repeat (n) @(negedge clk_50m);
                if (busy) begin
                    chk("hold_addr", bus.lcd_addr, ha);
                    chk("hold_data", bus.lcd_data, hd);
                end
                bus.lcd_done = 1'b1;
                @(negedge clk_50m);
                bus.lcd_done = 1'b0;
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_all();
        obs.delete();
        wr_cyc.delete();
        fd_cyc.delete();
        exp_q.delete();
    endtask

    task automatic pulse_req();
        @(negedge clk_50m);
        refresh_req = 1'b1;
        @(negedge clk_50m);
        refresh_req = 1'b0;
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_cyc.size() < n && k < budget) begin
            @(posedge clk_50m);
            k++;
        end
        if (fd_cyc.size() < n)
            chk("fd_timeout", fd_cyc.size(), n);
        @(negedge clk_50m);
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            @(posedge clk_50m);
            k++;
        end
        if (obs.size() < n)
            chk("wr_timeout", obs.size(), n);
        @(negedge clk_50m);
    endtask

    task automatic cmp_frame(input string tag);
        int m;
        chk({tag, "_n"}, obs.size(), exp_q.size());
        m = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk(tag, obs[i], exp_q[i]);
    endtask

    task automatic settle_idle(input string tag, input int frames);
        repeat (8) @(negedge clk_50m);
        chk({tag, "_fd"}, fd_cyc.size(), frames);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk_50m);
        chk("rst_wr", bus.lcd_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_tmo", tmo_err, 1'b0);
        chk("rst_addr_db", addr_db, 10'h000);
        chk("rst_lcd_addr", bus.lcd_addr, 10'h000);
        chk("rst_lcd_data", bus.lcd_data, 16'h0000);
        rst = 1'b0;
        repeat (5) @(negedge clk_50m);
        chk("idle_busy", busy, 1'b0);

        // Full frame, fixed driver latency of 3 cycles.
        clear_all();
        mask    = '1;
        fix_lat = 3;
        pulse_req();
        chk("busy_on", busy, 1'b1);
        wait_fd(1, 3000);
        add_cells(0, NCELL - 1);
        cmp_frame("full");
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("gap_full", wr_cyc[i] - wr_cyc[i-1], 3 + CHAR_LAT + 3);
        settle_idle("full", 1);
        chk("full_tmo", tmo_err, 1'b0);

        // Columns 12..15 skipped.
        clear_all();
        for (int i = 0; i < NCELL; i++)
            mask[i] = ((i % COLS) < 12);
        fix_lat = 0;
        pulse_req();
        wait_fd(1, 3000);
        add_cells(0, NCELL - 1);
        cmp_frame("skip");
        settle_idle("skip", 1);

        // State change during WAIT restarts the sweep without frame_done.
        for (int t = 0; t < 2; t++) begin
            clear_all();
            mask = '1;
            k    = (t == 0) ? 2 * COLS + 5 : int'($urandom_range(1, NCELL - 2));
            pulse_req();
            wait_obs(k + 1, 3000);
            state = state ^ 8'h03;
            wait_fd(1, 3000);
            add_cells(0, k);
            add_cells(0, NCELL - 1);
            cmp_frame("restart");
            settle_idle("restart", 1);
        end

        // Refresh while busy queues exactly one follow-on frame.
        clear_all();
        mask = '1;
        pulse_req();
        wait_obs(COLS + 3 + 1, 3000);
        refresh_req = 1'b1;
        @(negedge clk_50m);
        refresh_req = 1'b0;
        wait_fd(2, 6000);
        add_cells(0, NCELL - 1);
        add_cells(0, NCELL - 1);
        cmp_frame("pend");
        if (wr_cyc.size() > NCELL && fd_cyc.size() > 0)
            chk("pend_gap", wr_cyc[NCELL] - fd_cyc[0], CHAR_LAT + 2);
        settle_idle("pend", 2);

        // Random enable patterns, started by request or by state change.
        for (int t = 0; t < 4; t++) begin
            clear_all();
            mask = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                pulse_req();
            end else begin
                @(negedge clk_50m);
                state = state + 8'd1;
            end
            wait_fd(1, 3000);
            add_cells(0, NCELL - 1);
            cmp_frame("rand");
            settle_idle("rand", 1);
        end

        // Driver never answers: every cell times out.
        clear_all();
        mask    = '1;
        done_on = 1'b0;
        pulse_req();
        wait_fd(1, NCELL * 25 + 200);
        add_cells(0, NCELL - 1);
        cmp_frame("tmo");
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("gap_tmo", wr_cyc[i] - wr_cyc[i-1], DONE_TMO + CHAR_LAT + 3);
        chk("tmo_set", tmo_err, 1'b1);
        settle_idle("tmo", 1);

        clear_all();
        done_on = 1'b1;
        mask    = {$urandom, $urandom};
        pulse_req();
        wait_fd(1, 3000);
        add_cells(0, NCELL - 1);
        cmp_frame("tmo2");
        chk("tmo_sticky", tmo_err, 1'b1);

        // Reset in the middle of a handshake.
        clear_all();
        mask = '1;
        pulse_req();
        wait_obs(5, 3000);
        rst = 1'b1;
        @(negedge clk_50m);
        chk("mrst_wr", bus.lcd_wr, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_addr_db", addr_db, 10'h000);
        chk("mrst_tmo", tmo_err, 1'b0);
        rst = 1'b0;
        repeat (30) @(negedge clk_50m);
        chk("mrst_idle", busy, 1'b0);
        chk("mrst_nowr", obs.size(), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
